mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single RAM port between instruction fetch and the data (load/store) path of the core.
- Arbitrates fixed-priority data-first, with a streak limit so fetch cannot be starved by back-to-back data accesses.
- Sequences each access through RAM_IDLE/RAM_WAIT/RAM_DONE (ram_state_t).
- Returns a one-cycle ready pulse, plus a bus error on RAM timeout.

Parameters:
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending; legal range 1..15.
- RAM_TIMEOUT, 1024, maximum cycles spent in RAM_WAIT before abort; legal range 1..65535.
- ERR_DATA, 32'hDEADBEEF, load value returned on timeout.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iren  in  1  instruction read request; held until iready
- iaddr  in  32  fetch address (word_t)
- iload  out  32  fetched word, valid only while iready=1
- iready  out  1  one-cycle fetch completion pulse
- dren  in  1  data read request; held until dready
- dwen  in  1  data write request; held until dready
- daddr  in  32  data address
- dstore  in  32  store data
- dstrobe  in  4  byte enables for SB/SH/SW
- dload  out  32  load word, valid only while dready=1
- dready  out  1  one-cycle data completion pulse
- bus_err  out  1  asserted with iready/dready when the access timed out
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  32  RAM address
- ram_store  out  32  RAM write data
- ram_strobe  out  4  RAM byte enables (4'hF for reads)
- ram_load  in  32  RAM read data
- ram_ready  in  1  RAM access complete

Behaviour:
- Clocking: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: all outputs 0, state RAM_IDLE, streak counter 0, timeout counter 0.
- Reset mid-access: RAM strobes drop immediately (async). No ready pulse is issued. An interrupted write has undefined RAM effect.
- All outputs are registered. RAM-side signals are driven only from latched request registers.

RAM_IDLE:
- Grant selection:
  - If data is pending (dren|dwen) and (!iren or streak < MAX_DATA_STREAK): grant data.
  - Else if iren: grant instruction.
  - Else stay idle.
- On a grant: latch address/store/strobe and the grant (arb_grant_t), clear the timeout counter, go RAM_WAIT.
- If dren and dwen are both set, the access is a write. dren is ignored.
- Streak counter:
  - Data grant with iren high: increment, saturating at MAX_DATA_STREAK.
  - Instruction grant, or data grant with iren low: clear to 0.

RAM_WAIT:
- ram_ren/ram_wen, ram_addr, ram_store and ram_strobe are held constant throughout.
- Request inputs are ignored in this state. Deasserting a request does not abort the access; completion is still pulsed.
- On ram_ready=1:
  - Capture ram_load (reads only). Writes return 0 on dload.
  - Drop the RAM strobes on the next edge and go RAM_DONE.
- If the timeout counter reaches RAM_TIMEOUT-1 without ram_ready:
  - Drop the strobes, set the error flag and load register to ERR_DATA, go RAM_DONE.
- ram_ready asserted on the same cycle the timeout expires counts as success.

RAM_DONE:
- Assert exactly one of iready/dready for one cycle, with iload/dload valid and bus_err if flagged.
- Return to RAM_IDLE.
- The requester updates its request on the following cycle, so RAM_IDLE samples fresh requests.

Latency and throughput:
- Request seen in RAM_IDLE at cycle 0.
- Strobes high at cycle 1.
- ram_ready at cycle 1 gives the ready pulse at cycle 2.
- Minimum 3 cycles per access; no back-to-back overlap.
- ram_ready outside RAM_WAIT is ignored.

Invariants:
- ram_ren and ram_wen are never high together.
- iready and dready are never high together.
- Outputs iload/dload are 0 whenever their ready signal is low.

Decomposition:
- Existing package items used: ram_state_t and word_t.
- New package items:
  - arb_grant_t enum {GRANT_NONE, GRANT_I, GRANT_D}.
  - Localparam for the default ERR_DATA.
- No sub-module. The streak and timeout counters are inline; the timeout counter is 16 bits, the streak counter 4 bits.

Test Plan:
- Fetch only: iren=1, iaddr=0x100, RAM returns 0x00500093 with ready at 2 cycles latency -> ram_ren high 2 cycles with ram_addr=0x100, then iready pulse, iload=0x00500093, bus_err=0.
- Simultaneous request: iren=1 and dren=1 with daddr=0x2000 in the same cycle -> data is served first (dready, ram_addr=0x2000), then the fetch is served.
- Starvation guard: dren held continuously with iren=1 and MAX_DATA_STREAK=4 -> exactly 4 dready pulses, then 1 iready, then data resumes; streak counter is 0 after the fetch.
- Byte store: dwen=1, daddr=0x3001, dstore=0x0000AB00, dstrobe=4'b0010 -> ram_wen=1 with ram_strobe=4'b0010 and ram_store=0x0000AB00; dready with dload=0.
- Timeout: RAM_TIMEOUT=8, ram_ready never asserted -> strobes drop after 8 wait cycles, dready=1 with bus_err=1 and dload=0xDEADBEEF; the next access completes normally.
- Reset mid-wait: nRST low during RAM_WAIT -> ram_ren/ram_wen go to 0 asynchronously with no ready pulse; after release, a pending iren is granted from RAM_IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the RAM port arbiter
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RAM_IDLE,
        RAM_WAIT,
        RAM_DONE
    } ram_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    localparam word_t ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data load/store
//   CLK, nRST                      clock, async active-low reset
//   iren/iaddr -> iload/iready     fetch request and one-cycle completion
//   dren/dwen/daddr/dstore/dstrobe -> dload/dready   data request and completion
//   bus_err                        flags a timed-out access alongside its ready pulse
//   ram_*                          registered RAM strobes/address/data, ram_load/ram_ready back
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int    MAX_DATA_STREAK = 4,
    parameter int    RAM_TIMEOUT     = 1024,
    parameter word_t ERR_DATA        = ERR_DATA_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iren,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iready,
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [3:0]  dstrobe,
    output logic [31:0] dload,
    output logic        dready,
    output logic        bus_err,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    output logic [3:0]  ram_strobe,
    input  logic [31:0] ram_load,
    input  logic        ram_ready
);
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [15:0] TMO_LAST   = 16'(RAM_TIMEOUT - 1);

    ram_state_t  state_q, state_d;
    arb_grant_t  grant_q, grant_d;
    logic [3:0]  streak_q, streak_d;
    logic [15:0] tmo_q, tmo_d;
    logic        ren_d, wen_d, iready_d, dready_d, err_d;
    word_t       addr_d, store_d, iload_d, dload_d, rdata;
    logic [3:0]  strobe_d;
    logic        dreq;

    assign dreq = dren | dwen;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        ren_d    = ram_ren;
        wen_d    = ram_wen;
        addr_d   = ram_addr;
        store_d  = ram_store;
        strobe_d = ram_strobe;
        iready_d = 1'b0;
        dready_d = 1'b0;
        iload_d  = '0;
        dload_d  = '0;
        err_d    = 1'b0;
        rdata    = '0;
        unique case (state_q)
            RAM_IDLE: begin
                grant_d = (dreq && (!iren || streak_q < STREAK_MAX)) ? GRANT_D :
                          iren ? GRANT_I : GRANT_NONE;
                if (grant_d != GRANT_NONE) begin
                    state_d  = RAM_WAIT;
                    tmo_d    = '0;
                    wen_d    = grant_d == GRANT_D && dwen;
                    ren_d    = !wen_d;
                    addr_d   = grant_d == GRANT_D ? daddr : iaddr;
                    store_d  = wen_d ? dstore : '0;
                    strobe_d = wen_d ? dstrobe : 4'hF;
                    // Streak only builds while a fetch is actually being held off
                    streak_d = (grant_d == GRANT_D && iren) ?
                               (streak_q == STREAK_MAX ? streak_q : streak_q + 4'd1) : 4'd0;
                end
            end
            RAM_WAIT: begin
                // ram_ready wins over a timeout expiring on the same cycle
                if (ram_ready || tmo_q == TMO_LAST) begin
                    state_d  = RAM_DONE;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    rdata    = !ram_ready ? ERR_DATA : ram_ren ? ram_load : '0;
                    err_d    = !ram_ready;
                    iready_d = grant_q == GRANT_I;
                    dready_d = grant_q == GRANT_D;
                    iload_d  = iready_d ? rdata : '0;
                    dload_d  = dready_d ? rdata : '0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RAM_DONE: state_d = RAM_IDLE;
            default:  state_d = RAM_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= RAM_IDLE;
            grant_q    <= GRANT_NONE;
            streak_q   <= '0;
            tmo_q      <= '0;
            ram_ren    <= 1'b0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_store  <= '0;
            ram_strobe <= '0;
            iready     <= 1'b0;
            dready     <= 1'b0;
            iload      <= '0;
            dload      <= '0;
            bus_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            streak_q   <= streak_d;
            tmo_q      <= tmo_d;
            ram_ren    <= ren_d;
            ram_wen    <= wen_d;
            ram_addr   <= addr_d;
            ram_store  <= store_d;
            ram_strobe <= strobe_d;
            iready     <= iready_d;
            dready     <= dready_d;
            iload      <= iload_d;
            dload      <= dload_d;
            bus_err    <= err_d;
        end
    end

endmodule
